// File: rtl/regfile_ext_if.sv
// Register-access bus for regfile_ext.
//   master : system controller side (drives WrEn/RdEn/ADDR/WR_DATA/WR_MASK)
//   slave  : register file side (drives REG_EXP/EXP_UPD/RD_DATA/RD_DATA_VLD/ERR)
interface regfile_ext_if #(
  parameter int DATA_WD = 8,
  parameter int ADDR_WD = 4,
  parameter int NUM_EXP = 4
);
  logic                       WrEn;
  logic                       RdEn;
  logic [ADDR_WD-1:0]         ADDR;
  logic [DATA_WD-1:0]         WR_DATA;
  logic [DATA_WD-1:0]         WR_MASK;
  logic [NUM_EXP*DATA_WD-1:0] REG_EXP;
  logic [NUM_EXP-1:0]         EXP_UPD;
  logic [DATA_WD-1:0]         RD_DATA;
  logic                       RD_DATA_VLD;
  logic                       ERR;

  modport master (
    output WrEn, RdEn, ADDR, WR_DATA, WR_MASK,
    input  REG_EXP, EXP_UPD, RD_DATA, RD_DATA_VLD, ERR
  );

  modport slave (
    input  WrEn, RdEn, ADDR, WR_DATA, WR_MASK,
    output REG_EXP, EXP_UPD, RD_DATA, RD_DATA_VLD, ERR
  );
endinterface

// File: rtl/regfile_ext.sv
// Parametrised configuration register file.
//   CLK, RST : clock (rising edge), asynchronous active-high reset
//   bus      : regfile_ext_if.slave
//     WrEn/RdEn/ADDR/WR_DATA/WR_MASK : bit-masked write and 1-cycle-latency read
//     REG_EXP  : live contents of registers 0..NUM_EXP-1
//     EXP_UPD  : 1-cycle pulse per exported register whose value changed
//     RD_DATA/RD_DATA_VLD : read result and its valid pulse
//     ERR      : 1-cycle pulse on illegal address or write to a read-only register
module regfile_ext #(
  parameter int DATA_WD = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR_WD = 4,
  parameter int NUM_EXP = 4,
  parameter logic [DEPTH*DATA_WD-1:0] RST_VAL =
    ((DEPTH*DATA_WD)'(8'h20) << (3*DATA_WD)) |
    ((DEPTH*DATA_WD)'(8'h81) << (2*DATA_WD)),
  parameter logic [DEPTH-1:0] RO_MASK = '0
) (
  input logic           CLK,
  input logic           RST,
  regfile_ext_if.slave  bus
);

  logic [DEPTH-1:0][DATA_WD-1:0] regs;
  logic [DEPTH-1:0]              wr_sel;
  logic [DATA_WD-1:0]            rd_word;
  logic [DATA_WD-1:0]            wr_word;
  logic                          ro_hit;
  logic                          addr_ok;
  logic                          wr_chg;

  logic [DATA_WD-1:0]            rd_data;
  logic                          rd_vld;
  logic                          err;
  logic [NUM_EXP-1:0]            upd;

  // Widened by one bit so DEPTH == 2**ADDR_WD still compares correctly.
  assign addr_ok = {1'b0, bus.ADDR} < (ADDR_WD+1)'(DEPTH);

  // Address decode by scan rather than indexing, so an out-of-range ADDR
  // simply yields zero data and no read-only hit.
  always_comb begin
    rd_word = '0;
    ro_hit  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.ADDR == ADDR_WD'(i)) begin
        rd_word = regs[i];
        ro_hit  = RO_MASK[i];
      end
    end
  end

  assign wr_word = (rd_word & ~bus.WR_MASK) | (bus.WR_DATA & bus.WR_MASK);
  assign wr_chg  = wr_word != rd_word;

  for (genvar g = 0; g < DEPTH; g++) begin : g_sel
    assign wr_sel[g] = bus.WrEn && !RO_MASK[g] && (bus.ADDR == ADDR_WD'(g));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regs <= RST_VAL;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_sel[i]) regs[i] <= wr_word;
    end
  end

  // rd_word is sampled before the write lands, giving read-before-write
  // on a simultaneous access to the same address.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_data <= '0;
      rd_vld  <= 1'b0;
      err     <= 1'b0;
      upd     <= '0;
    end else begin
      rd_vld <= bus.RdEn;
      if (bus.RdEn) rd_data <= rd_word;
      err <= (bus.WrEn && (!addr_ok || ro_hit)) || (bus.RdEn && !addr_ok);
      upd <= wr_chg ? wr_sel[NUM_EXP-1:0] : '0;
    end
  end

  assign bus.REG_EXP     = regs[NUM_EXP-1:0];
  assign bus.EXP_UPD     = upd;
  assign bus.RD_DATA     = rd_data;
  assign bus.RD_DATA_VLD = rd_vld;
  assign bus.ERR         = err;

endmodule

// File: tb/tb_regfile_ext.sv
// Directed bench for regfile_ext. Three instances share one stimulus stream:
//   d0 : default parameters
//   d1 : RO_MASK = 16'h0004 (register 2 read-only)
//   d2 : DEPTH = 12 (addresses 12..15 illegal)
module tb_regfile_ext;
  logic       clk, rst;
  logic       wr_en, rd_en;
  logic [3:0] addr;
  logic [7:0] wdat, wmsk;

  int n_cmp = 0;
  int n_bad = 0;

  // d0 reference contents, used for the random sweep
  logic [7:0] m [16];
  logic [7:0] exp_rd;
  logic [3:0] exp_upd;

  regfile_ext_if #(.DATA_WD(8), .ADDR_WD(4), .NUM_EXP(4)) b0();
  regfile_ext_if #(.DATA_WD(8), .ADDR_WD(4), .NUM_EXP(4)) b1();
  regfile_ext_if #(.DATA_WD(8), .ADDR_WD(4), .NUM_EXP(4)) b2();

  assign b0.WrEn = wr_en; assign b0.RdEn = rd_en; assign b0.ADDR = addr;
  assign b0.WR_DATA = wdat; assign b0.WR_MASK = wmsk;
  assign b1.WrEn = wr_en; assign b1.RdEn = rd_en; assign b1.ADDR = addr;
  assign b1.WR_DATA = wdat; assign b1.WR_MASK = wmsk;
  assign b2.WrEn = wr_en; assign b2.RdEn = rd_en; assign b2.ADDR = addr;
  assign b2.WR_DATA = wdat; assign b2.WR_MASK = wmsk;

  regfile_ext #(.DATA_WD(8), .DEPTH(16), .ADDR_WD(4), .NUM_EXP(4))
    d0 (.CLK(clk), .RST(rst), .bus(b0.slave));
  regfile_ext #(.DATA_WD(8), .DEPTH(16), .ADDR_WD(4), .NUM_EXP(4), .RO_MASK(16'h0004))
    d1 (.CLK(clk), .RST(rst), .bus(b1.slave));
  regfile_ext #(.DATA_WD(8), .DEPTH(12), .ADDR_WD(4), .NUM_EXP(4))
    d2 (.CLK(clk), .RST(rst), .bus(b2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_rst();
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    m[2] = 8'h81;
    m[3] = 8'h20;
  endtask

  // One access cycle on d0's model, then sample #1 after the edge.
  task automatic acc(input logic we, input logic re, input logic [3:0] a,
                     input logic [7:0] d, input logic [7:0] mk);
    logic [7:0] nw;
    wr_en = we; rd_en = re; addr = a; wdat = d; wmsk = mk;
    exp_rd  = m[a];
    exp_upd = 4'b0000;
    if (we) begin
      nw = (m[a] & ~mk) | (d & mk);
      if (a < 4 && nw != m[a]) exp_upd = 4'b0001 << a;
      m[a] = nw;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    acc(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
  endtask

  initial begin
    logic [7:0] rd8, rm8;
    rst = 1'b1; wr_en = 0; rd_en = 0; addr = 0; wdat = 0; wmsk = 0;
    model_rst();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_exp", b0.REG_EXP, 32'h2081_0000);
    rst = 1'b0;
    idle();
    chk("rst_rd",  b0.RD_DATA, 32'h0);
    chk("rst_vld", b0.RD_DATA_VLD, 32'h0);
    chk("rst_err", b0.ERR, 32'h0);
    chk("rst_upd", b0.EXP_UPD, 32'h0);

    // Asynchronous reset with a write pending: no edge needed, no write lands
    acc(1'b1, 1'b0, 4'd0, 8'h11, 8'hFF);
    chk("pre_rst_exp", b0.REG_EXP, 32'h2081_0011);
    wr_en = 1'b1; addr = 4'd3; wdat = 8'hFF; wmsk = 8'hFF;
    #2 rst = 1'b1;
    #1 chk("async_rst_exp", b0.REG_EXP, 32'h2081_0000);
    @(posedge clk); #1;
    chk("midwr_rst_exp", b0.REG_EXP, 32'h2081_0000);
    chk("midwr_rst_upd", b0.EXP_UPD, 32'h0);
    rst = 1'b0;
    model_rst();
    idle();

    // Full write then read
    acc(1'b1, 1'b0, 4'd1, 8'hA5, 8'hFF);
    chk("wr1_exp", b0.REG_EXP, 32'h2081_A500);
    chk("wr1_upd", b0.EXP_UPD, 32'b0010);
    acc(1'b0, 1'b1, 4'd1, 8'h00, 8'h00);
    chk("rd1_data", b0.RD_DATA, 32'hA5);
    chk("rd1_vld", b0.RD_DATA_VLD, 32'h1);
    chk("rd1_upd", b0.EXP_UPD, 32'h0);
    idle();
    chk("idle_vld", b0.RD_DATA_VLD, 32'h0);
    chk("idle_hold", b0.RD_DATA, 32'hA5);

    // Masked write, then identical rewrite
    acc(1'b1, 1'b0, 4'd2, 8'h7E, 8'h0F);
    chk("mwr_exp", b0.REG_EXP, 32'h208E_A500);
    chk("mwr_upd", b0.EXP_UPD, 32'b0100);
    acc(1'b1, 1'b0, 4'd2, 8'h7E, 8'h0F);
    chk("mwr2_exp", b0.REG_EXP, 32'h208E_A500);
    chk("mwr2_upd", b0.EXP_UPD, 32'h0);

    // Zero mask is a legal no-op
    acc(1'b1, 1'b0, 4'd1, 8'hFF, 8'h00);
    chk("nomask_exp", b0.REG_EXP, 32'h208E_A500);
    chk("nomask_err", b0.ERR, 32'h0);
    chk("nomask_upd", b0.EXP_UPD, 32'h0);

    // Simultaneous read and write: old value returned
    acc(1'b1, 1'b1, 4'd3, 8'h55, 8'hFF);
    chk("rw_rd", b0.RD_DATA, 32'h20);
    chk("rw_vld", b0.RD_DATA_VLD, 32'h1);
    chk("rw_exp", b0.REG_EXP, 32'h558E_A500);
    chk("rw_upd", b0.EXP_UPD, 32'b1000);
    chk("rw_err", b0.ERR, 32'h0);
    acc(1'b0, 1'b1, 4'd3, 8'h00, 8'h00);
    chk("rw_rd2", b0.RD_DATA, 32'h55);

    // Read-only register on d1
    acc(1'b1, 1'b0, 4'd2, 8'h00, 8'hFF);
    chk("ro_exp", b1.REG_EXP, 32'h5581_A500);
    chk("ro_err", b1.ERR, 32'h1);
    chk("ro_upd", b1.EXP_UPD, 32'h0);
    chk("ro_d0_exp", b0.REG_EXP, 32'h5500_A500);
    chk("ro_d0_upd", b0.EXP_UPD, 32'b0100);
    chk("ro_d0_err", b0.ERR, 32'h0);

    // Illegal address on d2 (DEPTH 12)
    acc(1'b0, 1'b1, 4'd13, 8'h00, 8'h00);
    chk("ill_rd", b2.RD_DATA, 32'h0);
    chk("ill_vld", b2.RD_DATA_VLD, 32'h1);
    chk("ill_err", b2.ERR, 32'h1);
    chk("ro_err_end", b1.ERR, 32'h0);
    acc(1'b1, 1'b0, 4'd13, 8'hFF, 8'hFF);
    chk("illwr_err", b2.ERR, 32'h1);
    chk("illwr_exp", b2.REG_EXP, 32'h5500_A500);
    chk("illwr_upd", b2.EXP_UPD, 32'h0);
    acc(1'b1, 1'b1, 4'd13, 8'h0F, 8'hFF);
    chk("illrw_err", b2.ERR, 32'h1);
    chk("illrw_rd", b2.RD_DATA, 32'h0);
    chk("d0_r13_rd", b0.RD_DATA, 32'hFF);
    idle();
    chk("illrw_err_end", b2.ERR, 32'h0);

    // Back-to-back write/read sweep on d0
    for (int a = 0; a < 16; a++) begin
      rd8 = 8'($urandom_range(0, 255));
      rm8 = 8'($urandom_range(0, 255));
      acc(1'b1, 1'b0, 4'(a), rd8, rm8);
      chk($sformatf("sw_wr_err%0d", a), b0.ERR, 32'h0);
      chk($sformatf("sw_wr_vld%0d", a), b0.RD_DATA_VLD, 32'h0);
      chk($sformatf("sw_upd%0d", a), b0.EXP_UPD, 32'(exp_upd));
      acc(1'b0, 1'b1, 4'(a), 8'h00, 8'h00);
      chk($sformatf("sw_rd%0d", a), b0.RD_DATA, 32'(m[a]));
      chk($sformatf("sw_rd_vld%0d", a), b0.RD_DATA_VLD, 32'h1);
      chk($sformatf("sw_rd_err%0d", a), b0.ERR, 32'h0);
    end
    chk("sw_exp", b0.REG_EXP, {m[3], m[2], m[1], m[0]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
